// File: rtl/ir_decoder.sv
// NEC infrared remote decoder: leader validation, 32 pulse-distance bits,
// check-byte validation and a one-cycle strobe per good frame.
module ir_decoder #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        iIR,
    output logic        Get_Flag,
    output logic [15:0] irAddr,
    output logic [15:0] irData
);

    function automatic logic [19:0] us_to_cyc(input longint unsigned us);
        return 20'((64'(CLK_HZ) * us) / 64'd1_000_000);
    endfunction

    localparam logic [19:0] LL_MIN  = us_to_cyc(8500);
    localparam logic [19:0] LL_MAX  = us_to_cyc(9500);
    localparam logic [19:0] LH_MIN  = us_to_cyc(4000);
    localparam logic [19:0] LH_MAX  = us_to_cyc(5000);
    localparam logic [19:0] B_MIN   = us_to_cyc(400);
    localparam logic [19:0] B_MAX   = us_to_cyc(720);
    localparam logic [19:0] ONE_MIN = us_to_cyc(1500);
    localparam logic [19:0] ONE_MAX = us_to_cyc(1900);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  sync;
    logic [19:0] cnt;
    logic [4:0]  idx, idx_nxt;
    logic [31:0] shift, shift_nxt;
    logic        done, done_nxt;
    logic        fall, rise;
    logic        in_ll, in_lh, in_bit, in_one;
    logic        check_ok;

    // sync[2] is the previous conditioned sample, sync[1] the current one
    assign fall = sync[2] & ~sync[1];
    assign rise = ~sync[2] & sync[1];

    assign in_ll  = (cnt >= LL_MIN) && (cnt <= LL_MAX);
    assign in_lh  = (cnt >= LH_MIN) && (cnt <= LH_MAX);
    assign in_bit = (cnt >= B_MIN) && (cnt <= B_MAX);
    assign in_one = (cnt >= ONE_MIN) && (cnt <= ONE_MAX);

    assign check_ok = (shift[23:16] == ~shift[31:24]);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shift_nxt = shift;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) state_nxt = LEAD_LOW;
            end
            LEAD_LOW: begin
                if (rise) state_nxt = in_ll ? LEAD_HIGH : IDLE;
                else if (cnt > LL_MAX) state_nxt = IDLE;
            end
            LEAD_HIGH: begin
                if (fall) begin
                    if (in_lh) begin
                        state_nxt = BIT_LOW;
                        idx_nxt   = 5'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (cnt > LH_MAX) begin
                    state_nxt = IDLE;
                end
            end
            BIT_LOW: begin
                if (rise) state_nxt = in_bit ? BIT_HIGH : IDLE;
                else if (cnt > B_MAX) state_nxt = IDLE;
            end
            BIT_HIGH: begin
                if (fall) begin
                    if (in_bit || in_one) begin
                        shift_nxt = {in_one, shift[31:1]};
                        if (idx == 5'd31) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt   = idx + 5'd1;
                            state_nxt = BIT_LOW;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (cnt > ONE_MAX) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync     <= 3'b111;
            cnt      <= 20'd0;
            state    <= IDLE;
            idx      <= 5'd0;
            shift    <= 32'd0;
            done     <= 1'b0;
            Get_Flag <= 1'b0;
            irAddr   <= 16'd0;
            irData   <= 16'd0;
        end else begin
            sync  <= {sync[1:0], iIR};
            state <= state_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            done  <= done_nxt;
            if (fall || rise) cnt <= 20'd0;
            else if (cnt != 20'hFFFFF) cnt <= cnt + 20'd1;
            // Check runs one cycle after the last bit, once shift is final
            Get_Flag <= done && check_ok;
            if (done && check_ok) begin
                irAddr <= shift[15:0];
                irData <= shift[31:16];
            end
        end
    end

endmodule

// File: tb/tb_ir_decoder.sv
// Directed bench for ir_decoder, run at a 50 kHz clock (50 cycles per ms)
// so whole NEC frames stay short.
module tb_ir_decoder;

    localparam int unsigned CLK_HZ = 50_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir  = 1'b1;
    logic        get_flag;
    logic [15:0] ir_addr;
    logic [15:0] ir_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int flag_cyc = 0;
    int stop_cyc = 0;
    int p0;

    ir_decoder #(.CLK_HZ(CLK_HZ)) dut (
        .Clk(clk),
        .Rst(rst),
        .iIR(ir),
        .Get_Flag(get_flag),
        .irAddr(ir_addr),
        .irData(ir_data)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (get_flag === 1'b1) begin
            pulses++;
            flag_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic phase(input logic lvl, input int n);
        ir = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic leader();
        phase(1'b0, 450);
        phase(1'b1, 225);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            phase(1'b0, 28);
            phase(1'b1, w[i] ? 84 : 28);
        end
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [7:0] c,
                              input logic [7:0] k);
        leader();
        send_bits({k, c, a}, 32);
        stop_cyc = cyc;
        phase(1'b0, 28);
        phase(1'b1, 40);
    endtask

    initial begin
        repeat (10) @(posedge clk);
        #1;
        chk("rst_flag", {31'd0, get_flag}, 32'd0);
        chk("rst_addr", {16'd0, ir_addr}, 32'd0);
        chk("rst_data", {16'd0, ir_data}, 32'd0);
        rst = 1'b0;
        phase(1'b1, 20);

        p0 = pulses;
        send_frame(16'h0001, 8'h12, 8'hED);
        chk("f1_pulses", pulses - p0, 32'd1);
        chk("f1_latency", flag_cyc - stop_cyc, 32'd4);
        chk("f1_addr", {16'd0, ir_addr}, 32'h0001);
        chk("f1_data", {16'd0, ir_data}, 32'hED12);

        phase(1'b1, 3000);
        p0 = pulses;
        send_frame(16'h0003, 8'hEB, 8'h14);
        chk("f2_pulses", pulses - p0, 32'd1);
        chk("f2_addr", {16'd0, ir_addr}, 32'h0003);
        chk("f2_data", {16'd0, ir_data}, 32'h14EB);

        phase(1'b1, 200);
        p0 = pulses;
        send_frame(16'h0001, 8'h12, 8'h00);
        chk("bad_pulses", pulses - p0, 32'd0);
        chk("bad_addr", {16'd0, ir_addr}, 32'h0003);
        chk("bad_data", {16'd0, ir_data}, 32'h14EB);

        phase(1'b1, 200);
        p0 = pulses;
        phase(1'b0, 450);
        phase(1'b1, 112);
        phase(1'b0, 28);
        phase(1'b1, 300);
        chk("rep_pulses", pulses - p0, 32'd0);
        chk("rep_addr", {16'd0, ir_addr}, 32'h0003);
        chk("rep_data", {16'd0, ir_data}, 32'h14EB);
        send_frame(16'h00A5, 8'h3C, 8'hC3);
        chk("rep_next_addr", {16'd0, ir_addr}, 32'h00A5);
        chk("rep_next_data", {16'd0, ir_data}, 32'hC33C);

        phase(1'b1, 200);
        p0 = pulses;
        leader();
        send_bits(32'hFFFF_FFFF, 10);
        phase(1'b0, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_addr", {16'd0, ir_addr}, 32'd0);
        chk("mid_rst_data", {16'd0, ir_data}, 32'd0);
        phase(1'b1, 300);
        send_frame(16'h1234, 8'h5A, 8'hA5);
        chk("post_rst_pulses", pulses - p0, 32'd1);
        chk("post_rst_addr", {16'd0, ir_addr}, 32'h1234);
        chk("post_rst_data", {16'd0, ir_data}, 32'hA55A);

        phase(1'b1, 200);
        p0 = pulses;
        phase(1'b0, 450);
        phase(1'b1, 500);
        chk("tmo_pulses", pulses - p0, 32'd0);
        send_frame(16'hBEEF, 8'h01, 8'hFE);
        chk("tmo_next_pulses", pulses - p0, 32'd1);
        chk("tmo_next_addr", {16'd0, ir_addr}, 32'hBEEF);
        chk("tmo_next_data", {16'd0, ir_data}, 32'hFE01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_decoder.md
# ir_decoder

NEC-format infrared remote decoder for a 50 MHz clock domain. It samples the demodulated receiver pin, validates the 9 ms / 4.5 ms leader, and decodes 32 pulse-distance bits (LSB first) into a 16-bit address and a 16-bit data/check word. Each good frame is announced with a one-cycle strobe. It sits between the IR receiver pin and the command-handling logic.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency; all time windows below are converted to cycle counts from it.
- `Clk`  in  1  system clock, rising-edge active.
- `Rst`  in  1  reset. Synchronous, active-high.
- `iIR`  in  1  raw receiver output, asynchronous. Idle high; a carrier burst reads low.
- `Get_Flag`  out  1  one-cycle pulse when a valid frame has been decoded.
- `irAddr`  out  16  address of the last valid frame. Bit 0 is the first bit received.
- `irData`  out  16  data of the last valid frame. [7:0] = command, [15:8] = inverted command.

## Operation
- **Input conditioning.** `iIR` passes through a 2-flop synchronizer, then a third flop for edge detection. All three flops reset to 1.
  - Fall = previous 1, current 0. Rise = previous 0, current 1.
- **Duration counter.** 20-bit cycle counter, cleared on every detected edge, saturates at its maximum. Each phase is measured as the count at the closing edge.
- **Time windows** (ms, inclusive):
  - leader low: 8.5–9.5
  - leader high: 4.0–5.0
  - bit low: 0.40–0.72
  - bit high "0": 0.40–0.72
  - bit high "1": 1.50–1.90
- **States:** IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH.
  - **IDLE:** on fall → LEAD_LOW.
  - **LEAD_LOW:** on rise with count in leader-low window → LEAD_HIGH; otherwise → IDLE.
  - **LEAD_HIGH:** on fall with count in leader-high window → BIT_LOW, bit index cleared to 0; otherwise → IDLE. A 2.25 ms repeat leader fails this window and is ignored: no flag, outputs unchanged.
  - **BIT_LOW:** on rise with count in bit-low window → BIT_HIGH; otherwise → IDLE.
  - **BIT_HIGH:** on fall, classify the high time as 0 or 1 and shift it into a 32-bit register at the MSB end (right shift), so the first bit ends at [0]. A high time outside both windows → IDLE, frame dropped.
    - After bit 31 is classified → IDLE, and run the frame check.
    - Otherwise increment the index → BIT_LOW.
- **Timeout.** In any non-IDLE state, if the count exceeds that state's window maximum before the closing edge → IDLE. The final stop burst is not timed.
- **Frame check:** shift[23:16] == ~shift[31:24].
  - Pass: `irAddr` ← shift[15:0], `irData` ← shift[31:16], and `Get_Flag` is pulsed.
  - Fail: outputs unchanged, no pulse.
- **Output holding.** `irAddr` and `irData` hold their values until the next valid frame.

## Timing
- **Reset values:** `Get_Flag` = 0, `irAddr` = 0, `irData` = 0. State = IDLE, counter = 0, bit index = 0, shift register = 0, synchronizer = 1.
- **Reset mid-frame:** the decode is aborted immediately and all of the above are restored.
- **Edge latency:** an edge on `iIR` is acted on 3 cycles later.
- **Flag latency:** `Get_Flag` rises exactly 4 cycles after the falling edge of the stop burst. It is high for exactly 1 cycle.
- **Output update:** `irAddr` and `irData` change on the same edge on which `Get_Flag` rises.
- **Back-to-back frames:** after each frame the FSM returns to IDLE, so frames separated by any idle high time decode independently.
- **Glitches:** glitches shorter than 0.40 ms abort the current frame to IDLE; the next leader is decoded normally.

## Test plan
- **Frame 1.** Reset 10 cycles, then send a frame with address 16'h0001 and command 8'h12 (9 ms low, 4.5 ms high, bits of 0.56 ms low followed by 0.56/1.69 ms high, then a 0.56 ms stop burst).
  - Required: one `Get_Flag` pulse, `irAddr` = 16'h0001, `irData` = 16'hED12.
- **Frame 2.** 60 ms idle, then a frame with address 16'h0003 and command 8'hEB.
  - Required: one pulse, `irAddr` = 16'h0003, `irData` = 16'h14EB.
- **Bad check byte.** Frame with command 8'h12 and a check byte of 8'h00.
  - Required: no pulse; outputs keep the previous values.
- **Repeat code.** 9 ms low, 2.25 ms high, 0.56 ms low.
  - Required: no pulse, outputs unchanged, FSM back in IDLE.
- **Reset mid-frame.** Assert `Rst` for 1 cycle during bit 10, then send a full valid frame.
  - Required: outputs read 0 immediately after reset, then the new frame decodes correctly.
- **Timeout.** Leader followed by `iIR` held high for 10 ms.
  - Required: FSM returns to IDLE, no pulse, and the next valid frame decodes.
